// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg
//   Shared definitions for the parametrised single-clock FIFO: default
//   parameter values, pointer/address width helpers and the legality checks
//   that the top module evaluates at elaboration time.
package sync_fifo_pkg;

    // Default configuration (drop-in replacement for the fixed 8-bit FIFO)
    localparam int unsigned DefDataW    = 8;
    localparam int unsigned DefDepth    = 16;
    localparam int unsigned DefAeThresh = 2;

    // Storage index width
    function automatic int unsigned addr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Pointer / count width: index bits plus one wrap bit, so a count of
    // exactly DEPTH is representable.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // DEPTH must be a power of two and at least 2
    function automatic bit depth_ok(input int unsigned depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    // almost_full threshold: 1..DEPTH
    function automatic bit af_ok(input int unsigned depth, input int unsigned af);
        return (af >= 1) && (af <= depth);
    endfunction

    // almost_empty threshold: 0..DEPTH-1
    function automatic bit ae_ok(input int unsigned depth, input int unsigned ae);
        return ae < depth;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem
//   DEPTH x DATA_W register array backing the FIFO. One synchronous write
//   port and one asynchronous (combinational) read port. Contents are not
//   reset; occupancy is tracked by the FIFO controller.
//
// Ports
//   clk      in   write clock
//   wr_en    in   write strobe (already qualified by the controller)
//   wr_addr  in   write index
//   wr_data  in   write data
//   rd_addr  in   read index
//   rd_data  out  word at rd_addr, combinational
module fifo_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param
//   Parametrised single-clock FIFO with occupancy count, almost-full /
//   almost-empty flags, one-cycle overflow/underflow pulses, synchronous
//   flush and a selectable first-word-fall-through read mode.
//
// Parameters
//   DATA_W     data word width
//   DEPTH      number of entries (power of two, >= 2)
//   AF_THRESH  almost_full when count >= AF_THRESH (1..DEPTH)
//   AE_THRESH  almost_empty when count <= AE_THRESH (0..DEPTH-1)
//   FWFT       0: registered read, 1: head word shown on data_out
//
// Ports
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   clr           in   synchronous flush, overrides wr_en/rd_en
//   wr_en         in   write request
//   data_in       in   write data
//   rd_en         in   read request / head acknowledge in FWFT mode
//   data_out      out  read data
//   full          out  count == DEPTH
//   almost_full   out  count >= AF_THRESH
//   empty         out  count == 0
//   almost_empty  out  count <= AE_THRESH
//   count         out  occupancy 0..DEPTH
//   overflow      out  pulse: write attempted while full
//   underflow     out  pulse: read attempted while empty
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = DefDataW,
    parameter int unsigned DEPTH     = DefDepth,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = DefAeThresh,
    parameter bit          FWFT      = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      wr_en,
    input  logic [DATA_W-1:0]         data_in,
    input  logic                      rd_en,
    output logic [DATA_W-1:0]         data_out,
    output logic                      full,
    output logic                      almost_full,
    output logic                      empty,
    output logic                      almost_empty,
    output logic [ptr_w(DEPTH)-1:0]   count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int unsigned PtrW  = ptr_w(DEPTH);
    localparam int unsigned AddrW = addr_w(DEPTH);

    localparam logic [PtrW-1:0] DepthCnt = PtrW'(DEPTH);
    localparam logic [PtrW-1:0] AfCnt    = PtrW'(AF_THRESH);
    localparam logic [PtrW-1:0] AeCnt    = PtrW'(AE_THRESH);

    // Elaboration-time parameter legality checks
    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two >= 2");
    end
    if (!af_ok(DEPTH, AF_THRESH)) begin : g_bad_af
        $error("sync_fifo_param: AF_THRESH must be in 1..DEPTH");
    end
    if (!ae_ok(DEPTH, AE_THRESH)) begin : g_bad_ae
        $error("sync_fifo_param: AE_THRESH must be in 0..DEPTH-1");
    end
    if (DATA_W < 1) begin : g_bad_width
        $error("sync_fifo_param: DATA_W must be >= 1");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              af_q, af_d;
    logic              empty_q, empty_d;
    logic              ae_q, ae_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] mem_rdata;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // Acceptance uses only registered flags, so a read in the same cycle
        // never frees room for a write at full (and vice versa at empty).
        wr_acc = wr_en & ~full_q & ~clr;
        rd_acc = rd_en & ~empty_q & ~clr;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + PtrW'(wr_acc) - PtrW'(rd_acc);
        end

        // Flags are derived from count_d so that, once registered, they
        // always describe the count visible in the same cycle.
        full_d  = (count_d == DepthCnt);
        af_d    = (count_d >= AfCnt);
        empty_d = (count_d == '0);
        ae_d    = (count_d <= AeCnt);

        // Error pulses: a rejected request. Flush suppresses them.
        ovf_d = ~clr & wr_en & full_q;
        unf_d = ~clr & rd_en & empty_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            empty_q  <= 1'b1;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            af_q     <= af_d;
            empty_q  <= empty_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (AddrW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q[AddrW-1:0]),
        .wr_data (data_in),
        .rd_addr (rd_ptr_q[AddrW-1:0]),
        .rd_data (mem_rdata)
    );

    // ------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------
    if (FWFT) begin : g_fwft
        // Head word is presented directly; meaningless while empty.
        assign data_out = mem_rdata;
    end else begin : g_std
        logic [DATA_W-1:0] dout_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_q <= '0;
            end else if (clr) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= mem_rdata;
            end
        end

        assign data_out = dout_q;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign full         = full_q;
    assign almost_full  = af_q;
    assign empty        = empty_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule
